// File: rtl/ysyx_cdb_arb_if.sv
`default_nettype none

// ============================================================================
// Module      : ysyx_cdb_arb_if
// Description : Bundle of the execution-unit request side and the common
//               data bus broadcast side of the CDB arbiter.
//               master : execution units / ROB side (drives requests,
//                        observes accept and broadcast)
//               slave  : the arbiter (accepts requests, drives the CDB)
//               Signals:
//                 in_valid  [NREQ]        per-unit request
//                 in_ready  [NREQ]        per-unit accept
//                 in_dest   [NREQ*TAG_W]  per-unit tag, unit i at [i*TAG_W +: TAG_W]
//                 in_data   [NREQ*DATA_W] per-unit payload, same packing
//                 cdb_valid               broadcast valid
//                 cdb_dest  [TAG_W]       broadcast tag
//                 cdb_data  [DATA_W]      broadcast payload
//                 cdb_grant [NREQ]        one-hot source of the broadcast
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

interface ysyx_cdb_arb_if #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = $clog2(`YSYX_ROB_SIZE) + 1,
    parameter int DATA_W = 2 * `YSYX_XLEN + 2
);
    logic [NREQ-1:0]        in_valid;
    logic [NREQ-1:0]        in_ready;
    logic [NREQ*TAG_W-1:0]  in_dest;
    logic [NREQ*DATA_W-1:0] in_data;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_dest;
    logic [DATA_W-1:0]      cdb_data;
    logic [NREQ-1:0]        cdb_grant;

    modport master (
        output in_valid, in_dest, in_data,
        input  in_ready, cdb_valid, cdb_dest, cdb_data, cdb_grant
    );

    modport slave (
        input  in_valid, in_dest, in_data,
        output in_ready, cdb_valid, cdb_dest, cdb_data, cdb_grant
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_cdb_arb.sv
`default_nettype none

// ============================================================================
// Module      : ysyx_cdb_arb
// Description : Common-data-bus arbiter. Each execution unit owns a one-entry
//               result slot; every cycle at most one occupied slot is chosen
//               and broadcast combinationally on the CDB, then cleared unless
//               refilled in the same cycle.
//               Ports:
//                 clock     : clock
//                 reset     : synchronous, active-high reset
//                 flush     : synchronous pipeline flush (clears all slots)
//                 rob_head  : ROB head index, age reference for age priority
//                 bus       : ysyx_cdb_arb_if.slave (requests + CDB)
//               Configuration macro:
//                 YSYX_CDB_AGE_PRIO_EN : oldest-first (relative to rob_head)
//                                        arbitration; round-robin otherwise.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

module ysyx_cdb_arb #(
    parameter int NREQ     = 3,
    parameter int ROB_SIZE = `YSYX_ROB_SIZE,
    parameter int DATA_W   = 2 * `YSYX_XLEN + 2,
    parameter int TAG_W    = $clog2(ROB_SIZE) + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [$clog2(ROB_SIZE)-1:0] rob_head,
    ysyx_cdb_arb_if.slave               bus
);

    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int PTR_W = $clog2(NREQ);

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   r_slot_valid;
    logic [TAG_W-1:0]  r_slot_dest [NREQ];
    logic [DATA_W-1:0] r_slot_data [NREQ];

    logic [TAG_W-1:0]  w_in_dest [NREQ];
    logic [DATA_W-1:0] w_in_data [NREQ];

    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_ready;
    logic [NREQ-1:0]   w_load;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_found;

    logic [TAG_W-1:0]  w_cdb_dest;
    logic [DATA_W-1:0] w_cdb_data;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_in_dest[gi] = bus.in_dest[gi*TAG_W +: TAG_W];
            assign w_in_data[gi] = bus.in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A slot being drained this cycle can take a new result at the same edge.
    assign w_ready = {NREQ{!reset && !flush}} & (~r_slot_valid | w_grant);
    assign w_load  = bus.in_valid & w_ready;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset || flush) begin
                r_slot_valid[i] <= 1'b0;
                r_slot_dest[i]  <= '0;
                r_slot_data[i]  <= '0;
            end else if (w_load[i]) begin
                // Tag 0 means "no destination": accept but never broadcast.
                r_slot_valid[i] <= (w_in_dest[i] != '0);
                r_slot_dest[i]  <= w_in_dest[i];
                r_slot_data[i]  <= w_in_data[i];
            end else if (w_grant[i]) begin
                r_slot_valid[i] <= 1'b0;
            end
        end
    end

`ifdef YSYX_CDB_AGE_PRIO_EN
    // ------------------------------------------------------------------
    // Age priority: age = (tag - 1 - rob_head) mod ROB_SIZE; smallest wins.
    // Tags are unique in the ROB, so no two occupied slots share an age.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_age [NREQ];
    logic [IDX_W-1:0] w_best_age;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_age
            assign w_age[gi] = r_slot_dest[gi][IDX_W-1:0] - IDX_W'(1) - rob_head;
        end
    endgenerate

    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_best_age = '1;
        w_grant    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_slot_valid[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_best_age = w_age[i];
                w_win_idx  = PTR_W'(i);
            end
        end
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end
`else
    // ------------------------------------------------------------------
    // Round-robin: search from r_rr_ptr upward, wrapping modulo NREQ.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_scan_idx;
    logic             w_unused_rob_head;

    assign w_unused_rob_head = ^rob_head;

    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_scan_idx = '0;
        w_grant    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && r_slot_valid[w_scan_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan_idx;
            end
        end
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    // The pointer is held across a flush even if the flushed cycle granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (!flush && w_found) begin
            r_rr_ptr <= PTR_W'((int'(w_win_idx) + 1) % NREQ);
        end
    end
`endif

    // ------------------------------------------------------------------
    // CDB output mux: AND-OR over the one-hot grant, zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        w_cdb_dest = '0;
        w_cdb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_cdb_dest = w_cdb_dest | r_slot_dest[i];
                w_cdb_data = w_cdb_data | r_slot_data[i];
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.cdb_valid = |w_grant;
    assign bus.cdb_grant = w_grant;
    assign bus.cdb_dest  = w_cdb_dest;
    assign bus.cdb_data  = w_cdb_data;

endmodule

`default_nettype wire
